// File: rtl/intra_pkg.sv
// Shared definitions for the intra-prediction block fetchers: FSM states,
// fill value and width helpers used by the fetcher and its address generator.
package intra_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_ROWS,
    S_WAIT,
    S_HOLD
  } state_t;

  // Mid-grey fill for unavailable neighbours.
  function automatic int def_pix(input int pix_w);
    return 1 << (pix_w - 1);
  endfunction

  function automatic int lane_lsb(input int lane, input int pix_w);
    return lane * pix_w;
  endfunction

  function automatic int addr_width(input int frame_w, input int frame_h);
    return $clog2(frame_w * frame_h);
  endfunction

  function automatic int idx_width(input int frame_w, input int frame_h, input int blk);
    return $clog2((frame_w / blk) * (frame_h / blk));
  endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Raster macroblock index to frame position, and the row-stepped read address
// (top neighbour row first when present, then the block rows).
module mb_addr_gen
  import intra_pkg::*;
#(
  parameter int BLK     = 8,
  parameter int FRAME_W = 256,
  parameter int FRAME_H = 256,
  parameter int IDX_W   = idx_width(FRAME_W, FRAME_H, BLK),
  parameter int ADDR_W  = addr_width(FRAME_W, FRAME_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [IDX_W-1:0]  mb_index,
  output logic              dec_top,
  output logic              dec_left,
  output logic [ADDR_W-1:0] addr
);

  localparam int MB_ROW = FRAME_W / BLK;

  int r0;
  int c0;
  int first;

  always_comb begin
    r0       = (int'(mb_index) / MB_ROW) * BLK;
    c0       = (int'(mb_index) % MB_ROW) * BLK;
    dec_top  = (r0 > 0);
    dec_left = (c0 > 0);
    // Base column steps one left to pick up the left neighbour; the top read
    // sits one row above the block.
    first    = r0 * FRAME_W + c0 - (dec_left ? 1 : 0) - (dec_top ? FRAME_W : 0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= ADDR_W'(first);
    end else if (step) begin
      addr <= addr + ADDR_W'(FRAME_W);
    end
  end

endmodule

// File: rtl/mb_block_fetcher.sv
// Fetches one BLKxBLK block plus top/left/top-left neighbours, one frame row
// per cycle, and presents the result on a valid/ready handshake.
module mb_block_fetcher
  import intra_pkg::*;
#(
  parameter  int BLK     = 8,
  parameter  int FRAME_W = 256,
  parameter  int FRAME_H = 256,
  parameter  int PIX_W   = 8,
  localparam int ADDR_W  = addr_width(FRAME_W, FRAME_H),
  localparam int IDX_W   = idx_width(FRAME_W, FRAME_H, BLK)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [IDX_W-1:0]         mb_index,
  output logic                     busy,
  output logic                     idx_err,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [(BLK+1)*PIX_W-1:0] rd_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [BLK*BLK*PIX_W-1:0] blk_pix,
  output logic [BLK*PIX_W-1:0]     top_pix,
  output logic [BLK*PIX_W-1:0]     left_pix,
  output logic [PIX_W-1:0]         tl_pix,
  output logic                     top_avail,
  output logic                     left_avail
);

  localparam int              NUM_MB  = (FRAME_W / BLK) * (FRAME_H / BLK);
  localparam int              CNT_W   = $clog2(BLK);
  localparam logic [PIX_W-1:0] DEF_PIX = PIX_W'(def_pix(PIX_W));

  state_t               state;
  state_t               nxt;
  logic                 idx_ok;
  logic                 accept;
  logic                 bad;
  logic                 dec_top;
  logic                 dec_left;
  logic [ADDR_W-1:0]    addr;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     pv_row;
  logic                 pv;
  logic                 pv_top;
  logic [BLK*PIX_W-1:0] row_lanes;
  logic [PIX_W-1:0]     lane0;

  assign idx_ok    = (int'(mb_index) < NUM_MB);
  // Lane 0 carries the left neighbour whenever the block is not in column 0.
  assign row_lanes = rd_data[lane_lsb(int'(left_avail), PIX_W) +: BLK*PIX_W];
  assign lane0     = rd_data[PIX_W-1:0];

  mb_addr_gen #(
    .BLK     (BLK),
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .IDX_W   (IDX_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (rd_en),
    .mb_index (mb_index),
    .dec_top  (dec_top),
    .dec_left (dec_left),
    .addr     (addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // NOTE: nxt takes a default before the case, so no latch is inferred.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start && idx_ok) nxt = dec_top ? S_TOP : S_ROWS;
      S_TOP:  nxt = S_ROWS;
      S_ROWS: if (cnt == CNT_W'(BLK - 1)) nxt = S_WAIT;
      S_WAIT: nxt = S_HOLD;
      S_HOLD: if (blk_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en     = 1'b0;
    rd_addr   = '0;
    blk_valid = 1'b0;
    accept    = 1'b0;
    bad       = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        accept = start && idx_ok;
        bad    = start && !idx_ok;
      end
      S_TOP, S_ROWS: begin
        rd_en   = 1'b1;
        rd_addr = addr;
      end
      S_HOLD:  blk_valid = 1'b1;
      default: ;
    endcase
  end

  // pv/pv_top/pv_row follow each read by one cycle to steer its response.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the result registers are reset rather than left as plain
      // storage because every output must read 0 after reset.
      cnt        <= '0;
      pv         <= 1'b0;
      pv_top     <= 1'b0;
      pv_row     <= '0;
      idx_err    <= 1'b0;
      blk_pix    <= '0;
      top_pix    <= '0;
      left_pix   <= '0;
      tl_pix     <= '0;
      top_avail  <= 1'b0;
      left_avail <= 1'b0;
    end else begin
      idx_err <= bad;
      pv      <= rd_en;
      pv_top  <= (state == S_TOP);
      pv_row  <= cnt;
      if (state == S_ROWS) cnt <= cnt + 1'b1;
      if (accept) begin
        cnt        <= '0;
        top_avail  <= dec_top;
        left_avail <= dec_left;
        if (!dec_top)              top_pix  <= {BLK{DEF_PIX}};
        if (!dec_left)             left_pix <= {BLK{DEF_PIX}};
        if (!dec_top || !dec_left) tl_pix   <= DEF_PIX;
      end
      if (pv) begin
        if (pv_top) begin
          top_pix <= row_lanes;
          if (left_avail) tl_pix <= lane0;
        end else begin
          blk_pix[int'(pv_row)*BLK*PIX_W +: BLK*PIX_W] <= row_lanes;
          if (left_avail) left_pix[int'(pv_row)*PIX_W +: PIX_W] <= lane0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mb_block_fetcher.sv
// Bench for mb_block_fetcher: vector table plus scoreboard of expected blocks
// computed from a behavioural frame model, with reset and hold corner cases.
module tb_mb_block_fetcher;

  parameter int BLK = 8;
  localparam int PIX_W  = 8;
  localparam int FW     = 256;
  localparam int FH     = 256 - BLK;
  localparam int MBR    = FW / BLK;
  localparam int NUM_MB = MBR * (FH / BLK);
  localparam int IDX_W  = $clog2(NUM_MB);
  localparam int ADDR_W = $clog2(FW * FH);
  localparam int BUDGET = 4 * BLK + 20;
  localparam logic [7:0] DEF = 8'd128;

  typedef struct {
    int idx;
    bit pat;
    int hold;
    bit err;
    int reads;
    bit top;
    bit left;
    int first;
    int last;
  } vec_t;

  typedef struct {
    logic [BLK*BLK*8-1:0] blk;
    logic [BLK*8-1:0]     top;
    logic [BLK*8-1:0]     left;
    logic [7:0]           tl;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [IDX_W-1:0]         mb_index;
  logic                     busy;
  logic                     idx_err;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [(BLK+1)*PIX_W-1:0] rd_data;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [BLK*BLK*PIX_W-1:0] blk_pix;
  logic [BLK*PIX_W-1:0]     top_pix;
  logic [BLK*PIX_W-1:0]     left_pix;
  logic [PIX_W-1:0]         tl_pix;
  logic                     top_avail;
  logic                     left_avail;

  mb_block_fetcher #(
    .BLK(BLK), .FRAME_W(FW), .FRAME_H(FH), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mb_index(mb_index),
    .busy(busy), .idx_err(idx_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_pix(blk_pix), .top_pix(top_pix), .left_pix(left_pix),
    .tl_pix(tl_pix), .top_avail(top_avail), .left_avail(left_avail)
  );

  exp_t sb[$];
  exp_t got;
  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;
  int   viol  = 0;
  bit   pat_sel = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Frame content: pattern 0 is the (r+c) ramp, pattern 1 breaks row/column symmetry.
  function automatic logic [7:0] pix(input int r, input int c, input bit p);
    return p ? 8'((r * 13) ^ (c * 5)) : 8'(r + c);
  endfunction

  function automatic exp_t model(input int idx, input bit p);
    exp_t e;
    int r0 = (idx / MBR) * BLK;
    int c0 = (idx % MBR) * BLK;
    for (int i = 0; i < BLK; i++)
      for (int j = 0; j < BLK; j++)
        e.blk[(i*BLK+j)*8 +: 8] = pix(r0 + i, c0 + j, p);
    for (int j = 0; j < BLK; j++) e.top[j*8 +: 8]  = (r0 > 0) ? pix(r0 - 1, c0 + j, p) : DEF;
    for (int i = 0; i < BLK; i++) e.left[i*8 +: 8] = (c0 > 0) ? pix(r0 + i, c0 - 1, p) : DEF;
    e.tl = (r0 > 0 && c0 > 0) ? pix(r0 - 1, c0 - 1, p) : DEF;
    return e;
  endfunction

  // Frame memory: one-cycle latency; random data when no read is issued.
  always @(posedge clk) begin
    if (rd_en) begin
      if ((int'(rd_addr) % FW) + BLK > FW - 1 || int'(rd_addr) >= FW * FH) viol <= viol + 1;
      for (int j = 0; j <= BLK; j++)
        rd_data[j*8 +: 8] <= pix(int'(rd_addr) / FW, int'(rd_addr) % FW + j, pat_sel);
    end else begin
      for (int j = 0; j <= BLK; j++) rd_data[j*8 +: 8] <= 8'($urandom);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [2047:0] act,
                           input logic [2047:0] exp, input int npix);
    int bad = -1;
    n_vec++;
    for (int p = 0; p < npix; p++) begin
      if (act[p*8 +: 8] !== exp[p*8 +: 8]) begin
        bad = p;
        break;
      end
    end
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: pixel %0d got %0d expected %0d", name, bad,
               act[bad*8 +: 8], exp[bad*8 +: 8]);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_blk_valid"}, blk_valid, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_idx_err"}, idx_err, 0);
    check({tag, "_avail"}, {top_avail, left_avail}, 0);
    check({tag, "_tl_pix"}, tl_pix, 0);
    check_vec({tag, "_blk_pix"}, blk_pix, '0, BLK * BLK);
    check_vec({tag, "_top_pix"}, top_pix, '0, BLK);
    check_vec({tag, "_left_pix"}, left_pix, '0, BLK);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_fetch(input vec_t v);
    int   lat = 0;
    int   nrd = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    int   k = 1;
    int   viol0;
    logic [ADDR_W-1:0] a_first = '0;
    logic [ADDR_W-1:0] a_last = '0;
    exp_t snap;
    exp_t e;

    viol0   = viol;
    pat_sel = v.pat;
    @(negedge clk);
    start    = 1'b1;
    mb_index = IDX_W'(v.idx);
    if (!v.err) sb.push_back(model(v.idx, v.pat));
    @(negedge clk);
    start = 1'b0;

    if (v.err) begin
      check("idx_err_pulse", idx_err, 1);
      check("err_busy", busy, 0);
      check("err_rd_en", rd_en, 0);
      @(negedge clk);
      check("idx_err_single", idx_err, 0);
      check("err_busy_after", busy, 0);
      check("err_rd_en_after", rd_en, 0);
      return;
    end

    check("busy_on_accept", busy, 1);
    while (k <= BUDGET) begin
      if (rd_en) begin
        nrd++;
        if (first_cyc < 0) begin
          first_cyc = k;
          a_first   = rd_addr;
        end
        last_cyc = k;
        a_last   = rd_addr;
      end
      if (blk_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (lat == 0) begin
      check("valid_timeout", 0, 1);
      do_reset(2);
      sb.delete();
      return;
    end

    check("latency", lat, v.reads + 2);
    check("read_count", nrd, v.reads);
    check("read_contiguous", last_cyc - first_cyc + 1, v.reads);
    check("first_read_cycle", first_cyc, 1);
    check("first_addr", a_first, v.first);
    check("last_addr", a_last, v.last);
    check("top_avail", top_avail, v.top);
    check("left_avail", left_avail, v.left);

    snap = '{blk: blk_pix, top: top_pix, left: left_pix, tl: tl_pix};
    blk_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      start    = 1'b1;
      mb_index = IDX_W'(0);
      @(negedge clk);
      check("hold_stable", (blk_pix === snap.blk) && (top_pix === snap.top) &&
            (left_pix === snap.left) && (tl_pix === snap.tl), 1);
      check("hold_valid", blk_valid, 1);
      check("hold_no_read", rd_en, 0);
    end

    start     = 1'b1;
    blk_ready = 1'b1;
    got = '{blk: blk_pix, top: top_pix, left: left_pix, tl: tl_pix};
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check_vec("blk_pix", blk_pix, e.blk, BLK * BLK);
      check_vec("top_pix", top_pix, e.top, BLK);
      check_vec("left_pix", left_pix, e.left, BLK);
      check("tl_pix", tl_pix, e.tl);
    end
    @(negedge clk);
    start     = 1'b0;
    blk_ready = 1'b0;
    check("valid_drop", blk_valid, 0);
    check("busy_drop", busy, 0);
    @(negedge clk);
    check("start_at_handshake_ignored", busy, 0);
    check("frame_edge", viol - viol0, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mb_index  = '0;
    blk_ready = 1'b0;

    //           idx        pat hold err reads    top left first                         last
    vecs[0] = '{0,          0, 0, 0, BLK,     0, 0, 0,                            (BLK-1)*FW};
    vecs[1] = '{MBR+1,      0, 0, 0, BLK+1,   1, 1, (BLK-1)*FW+BLK-1,             (2*BLK-1)*FW+BLK-1};
    vecs[2] = '{MBR-1,      0, 0, 0, BLK,     0, 1, FW-BLK-1,                     (BLK-1)*FW+FW-BLK-1};
    vecs[3] = '{MBR,        1, 5, 0, BLK+1,   1, 0, (BLK-1)*FW,                   (2*BLK-1)*FW};
    vecs[4] = '{2*MBR-1,    1, 0, 0, BLK+1,   1, 1, (BLK-1)*FW+FW-BLK-1,          (2*BLK-1)*FW+FW-BLK-1};
    vecs[5] = '{1,          1, 2, 0, BLK,     0, 1, BLK-1,                        (BLK-1)*FW+BLK-1};
    vecs[6] = '{NUM_MB-1,   1, 1, 0, BLK+1,   1, 1, (FH-BLK-1)*FW+FW-BLK-1,       (FH-1)*FW+FW-BLK-1};
    vecs[7] = '{NUM_MB,     0, 0, 1, 0,       0, 0, 0,                            0};
    vecs[8] = '{(1<<IDX_W)-1, 0, 0, 1, 0,     0, 0, 0,                            0};
    vecs[9] = '{MBR+1,      1, 3, 0, BLK+1,   1, 1, (BLK-1)*FW+BLK-1,             (2*BLK-1)*FW+BLK-1};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) do_fetch(vecs[i]);

    // Interior block on the ramp: hand-derived neighbour values.
    do_fetch(vecs[1]);
    check("interior_blk0", got.blk[7:0], 2 * BLK);
    check("interior_top0", got.top[7:0], 2 * BLK - 1);
    check("interior_left0", got.left[7:0], 2 * BLK - 1);
    check("interior_tl", got.tl, 2 * BLK - 2);

    // Corner block 0: every neighbour is mid-grey.
    do_fetch(vecs[0]);
    check("corner_top0", got.top[7:0], 128);
    check("corner_left_last", got.left[(BLK-1)*8 +: 8], 128);
    check("corner_tl", got.tl, 128);

    // Last block of row 0: left column is frame column FW-BLK-1.
    do_fetch(vecs[2]);
    check("lastcol_left_last", got.left[(BLK-1)*8 +: 8], (BLK - 1 + FW - BLK - 1) & 255);

    // Reset on the 4th ROWS cycle, then a clean fetch of index 1.
    pat_sel = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    mb_index = IDX_W'(MBR + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_reset_reading", rd_en, 1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("mid_reset");
    reset = 1'b0;
    do_fetch(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
